// File: rtl/mips_loader_pkg.sv
// Shared constants and state encodings for the UART instruction-memory boot loader.
package mips_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the boot loader.
interface imem_uart_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  import mips_loader_pkg::*;

  logic                    imem_we;
  logic [ADDR_WIDTH-1:0]   imem_addr;
  logic [WORD_WIDTH-1:0]   imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte_valid
// on the stop-bit sample with frame_err qualifying it.
module uart_rx_byte
  import mips_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // a start bit that is high again at mid-bit is a glitch
          state_d   = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          ferr_d  = ~rx_sync_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = shift_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Packet FSM that loads a UART-delivered program image into instruction memory and
// releases the core from reset once the checksum verifies.
module imem_uart_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  imem_uart_loader_if.master  imem,
  output logic                core_rst_n,
  output logic                loading,
  output logic                done,
  output logic                err
);

  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  loader_state_e           state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             word_idx_q, word_idx_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [WORD_WIDTH-1:0]   asm_q, asm_d;
  logic [7:0]              csum_q, csum_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    loading_q, done_q, err_q, core_rst_n_q;
  logic [15:0]             len_full;

  assign len_full = {len_q[15:8], byte_data};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (byte_valid) begin
      if (frame_err) begin
        // corrupted bytes only abort a packet in flight; between packets they are dropped
        if (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM}) state_d = ST_ERROR;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (byte_data == SYNC_BYTE) begin
              state_d    = ST_LEN_HI;
              csum_d     = '0;
              word_idx_d = '0;
              byte_cnt_d = '0;
            end
          end
          ST_LEN_HI: begin
            len_d   = {byte_data, len_q[7:0]};
            csum_d  = csum_q ^ byte_data;
            state_d = ST_LEN_LO;
          end
          ST_LEN_LO: begin
            len_d  = len_full;
            csum_d = csum_q ^ byte_data;
            if ({1'b0, len_full} > MAX_LEN) state_d = ST_ERROR;
            else if (len_full == '0)        state_d = ST_CSUM;
            else                            state_d = ST_DATA;
          end
          ST_DATA: begin
            asm_d      = {asm_q[23:0], byte_data};
            csum_d     = csum_q ^ byte_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              we_d    = 1'b1;
              addr_d  = word_idx_q[ADDR_WIDTH-1:0];
              wdata_d = {asm_q[23:0], byte_data};
              if (word_idx_q + 16'd1 == len_q) state_d = ST_CSUM;
              else                             word_idx_d = word_idx_q + 16'd1;
            end
          end
          ST_CSUM: state_d = (byte_data == csum_q) ? ST_DONE : ST_ERROR;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      csum_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      loading_q    <= state_d inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM};
      done_q       <= (state_d == ST_DONE);
      err_q        <= (state_d == ST_ERROR);
      core_rst_n_q <= (state_d == ST_DONE);
    end
  end

  assign imem.imem_we    = we_q;
  assign imem.imem_addr  = addr_q;
  assign imem.imem_wdata = wdata_q;
  assign core_rst_n      = core_rst_n_q;
  assign loading         = loading_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule
